pc_sequencer: RTL and testbench

- Program-counter sequencer for the CPU front end.
- Owns the instruction address and the return-address stack.
- Resolves jump, conditional jump, call and return requests decoded by the control logic, using the ALU zero flag.
- Drives instr_addr to instruction memory, and halts on stack faults until reset.

---
 rtl/pc_sequencer_pkg.sv | 20 ++
 rtl/return_stack.sv | 52 +++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// request priority order and default sizes.
package pc_sequencer_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Bit positions in the request vector; a lower index wins arbitration.
    localparam int PRIO_RET = 0;
    localparam int PRIO_CAL = 1;
    localparam int PRIO_JMP = 2;
    localparam int PRIO_JZ  = 3;
    localparam int NUM_REQ  = 4;

    localparam int PC_WIDTH_DEF    = 5;
    localparam int STACK_DEPTH_DEF = 8;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses with a depth counter and full/empty flags.
// The stack knows nothing about PC or faults; the caller must not push when full or pop when empty.
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic [WIDTH-1:0]         top_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // DEPTH is a power of two, so the low bits of depth wrap cleanly.
    assign wr_idx  = depth_q[AW-1:0];
    assign rd_idx  = depth_q[AW-1:0] - AW'(1);
    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign top_o   = empty_o ? '0 : stack_q[rd_idx];
    assign depth_o = depth_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= '0;
        end else if (push_i && !full_o) begin
            depth_q <= depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            stack_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: resolves ret/cal/jmp/jz requests, owns the PC
// and the return stack, and halts on stack faults until reset.
//
// state   | meaning
// ST_RUN  | fetching; one request accepted per unstalled cycle
// ST_HALT | stack fault seen; PC, stack and flags frozen until rst_i
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                    PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                    STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [PC_WIDTH-1:0]   RESET_ADDR  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           stall_i,
    input  logic                           jmp_i,
    input  logic                           jz_i,
    input  logic                           cal_i,
    input  logic                           ret_i,
    input  logic                           zero_flag_i,
    input  logic [PC_WIDTH-1:0]            jmp_addr_i,
    output logic [PC_WIDTH-1:0]            instr_addr_o,
    output logic                           fetch_valid_o,
    output logic                           push_o,
    output logic                           pop_o,
    output logic [PC_WIDTH-1:0]            ret_addr_o,
    output logic [$clog2(STACK_DEPTH):0]   depth_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [NUM_REQ-1:0]    req;
    logic                  stk_full, stk_empty;

    assign req[PRIO_RET] = ret_i;
    assign req[PRIO_CAL] = cal_i;
    assign req[PRIO_JMP] = jmp_i;
    assign req[PRIO_JZ]  = jz_i;

    assign pc_inc = pc_q + PC_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push_o      = 1'b0;
        pop_o       = 1'b0;
        if (state_q == ST_RUN && !stall_i) begin
            if (req[PRIO_RET]) begin
                if (!stk_empty) begin
                    pc_d  = ret_addr_o;
                    pop_o = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end else if (req[PRIO_CAL]) begin
                if (!stk_full) begin
                    pc_d   = jmp_addr_i;
                    push_o = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = ST_HALT;
                end
            end else if (req[PRIO_JMP]) begin
                pc_d = jmp_addr_i;
            end else if (req[PRIO_JZ]) begin
                pc_d = zero_flag_i ? jmp_addr_i : pc_inc;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_ADDR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_o),
        .pop_i       (pop_o),
        .push_data_i (pc_inc),
        .top_o       (ret_addr_o),
        .depth_o     (depth_o),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign instr_addr_o  = pc_q;
    assign fetch_valid_o = (state_q == ST_RUN);
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues hand-computed expectations,
// the monitor checks strobes mid-cycle and registered outputs after each edge.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0, jmp = 1'b0, jz = 1'b0, cal = 1'b0, ret = 1'b0, zf = 1'b0;
    logic [4:0] jmp_addr = '0;
    logic [4:0] instr_addr, ret_addr;
    logic [3:0] depth;
    logic       fetch_valid, push, pop, overflow, underflow;

    typedef struct {
        logic       chk_strobe;
        logic       push;
        logic       pop;
        logic [4:0] pc;
        logic       fv;
        logic [3:0] depth;
        logic [4:0] ra;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .jmp_i         (jmp),
        .jz_i          (jz),
        .cal_i         (cal),
        .ret_i         (ret),
        .zero_flag_i   (zf),
        .jmp_addr_i    (jmp_addr),
        .instr_addr_o  (instr_addr),
        .fetch_valid_o (fetch_valid),
        .push_o        (push),
        .pop_o         (pop),
        .ret_addr_o    (ret_addr),
        .depth_o       (depth),
        .overflow_o    (overflow),
        .underflow_o   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Inputs are applied on the falling edge; the expectation describes the
    // strobes during this cycle and the outputs after the next rising edge.
    task automatic step(input logic r, input logic st, input logic j, input logic z,
                        input logic c, input logic rt, input logic f, input logic [4:0] a,
                        input logic e_push, input logic e_pop, input logic [4:0] e_pc,
                        input logic e_fv, input logic [3:0] e_d, input logic [4:0] e_ra,
                        input logic e_ovf, input logic e_udf);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; jmp = j; jz = z; cal = c; ret = rt; zf = f; jmp_addr = a;
        e.chk_strobe = !r;
        e.push = e_push; e.pop = e_pop; e.pc = e_pc; e.fv = e_fv;
        e.depth = e_d; e.ra = e_ra; e.ovf = e_ovf; e.udf = e_udf;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] e_pc, input logic e_fv, input logic [3:0] e_d,
                        input logic [4:0] e_ra, input logic e_ovf, input logic e_udf);
        step(0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, e_pc, e_fv, e_d, e_ra, e_ovf, e_udf);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (e.chk_strobe) begin
                    chk("push", {7'd0, push}, {7'd0, e.push});
                    chk("pop",  {7'd0, pop},  {7'd0, e.pop});
                end
                @(posedge clk);
                #1;
                chk("instr_addr",  {3'd0, instr_addr}, {3'd0, e.pc});
                chk("fetch_valid", {7'd0, fetch_valid}, {7'd0, e.fv});
                chk("depth",       {4'd0, depth},      {4'd0, e.depth});
                chk("ret_addr",    {3'd0, ret_addr},   {3'd0, e.ra});
                chk("overflow",    {7'd0, overflow},   {7'd0, e.ovf});
                chk("underflow",   {7'd0, underflow},  {7'd0, e.udf});
            end
        end
    end

    initial begin : driver
        logic [4:0] pc_before;
        //   rst st jmp jz cal ret zf addr  push pop pc fv d ra ovf udf
        step(1, 0, 0, 0, 0, 0, 0, 5'd0,  0, 0, 5'd0,  1, 0, 5'd0,  0, 0);
        idle(5'd1, 1, 0, 5'd0, 0, 0);
        idle(5'd2, 1, 0, 5'd0, 0, 0);
        idle(5'd3, 1, 0, 5'd0, 0, 0);
        idle(5'd4, 1, 0, 5'd0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd20, 1, 0, 5'd20, 1, 1, 5'd5,  0, 0);
        idle(5'd21, 1, 1, 5'd5, 0, 0);
        idle(5'd22, 1, 1, 5'd5, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5'd0,  0, 1, 5'd5,  1, 0, 5'd0,  0, 0);
        idle(5'd6, 1, 0, 5'd0, 0, 0);
        idle(5'd7, 1, 0, 5'd0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 5'd10, 0, 0, 5'd8,  1, 0, 5'd0,  0, 0);
        step(0, 0, 0, 1, 0, 0, 1, 5'd10, 0, 0, 5'd10, 1, 0, 5'd0,  0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 5'd10, 0, 0, 5'd10, 1, 0, 5'd0,  0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 5'd2,  0, 0, 5'd10, 1, 0, 5'd0,  0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd12, 1, 0, 5'd12, 1, 1, 5'd11, 0, 0);
        // ret, cal and jmp together: only the return is taken
        step(0, 0, 1, 0, 1, 1, 0, 5'd25, 0, 1, 5'd11, 1, 0, 5'd0,  0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 5'd31, 0, 0, 5'd31, 1, 0, 5'd0,  0, 0);
        idle(5'd0, 1, 0, 5'd0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 5'd31, 0, 0, 5'd31, 1, 0, 5'd0,  0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd3,  1, 0, 5'd3,  1, 1, 5'd0,  0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5'd0,  0, 1, 5'd0,  1, 0, 5'd0,  0, 0);
        // eight nested calls from PC 0: call i targets 8+i and pushes the caller's PC+1
        for (int i = 0; i < 8; i++) begin
            pc_before = (i == 0) ? 5'd0 : 5'(i + 7);
            step(0, 0, 0, 0, 1, 0, 0, 5'(i + 8), 1, 0, 5'(i + 8), 1, 4'(i + 1),
                 pc_before + 5'd1, 0, 0);
        end
        step(0, 0, 0, 0, 1, 0, 0, 5'd2,  0, 0, 5'd15, 0, 8, 5'd15, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 5'd1,  0, 0, 5'd15, 0, 8, 5'd15, 1, 0);
        idle(5'd15, 0, 8, 5'd15, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd0,  0, 0, 5'd0,  1, 0, 5'd0,  0, 0);
        idle(5'd1, 1, 0, 5'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5'd0,  0, 0, 5'd1,  0, 0, 5'd0,  0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 5'd5,  0, 0, 5'd1,  0, 0, 5'd0,  0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 5'd0,  0, 0, 5'd1,  0, 0, 5'd0,  0, 1);
        // reset wins over a simultaneous call, even while halted
        step(1, 0, 0, 0, 1, 0, 0, 5'd9,  0, 0, 5'd0,  1, 0, 5'd0,  0, 0);
        idle(5'd1, 1, 0, 5'd0, 0, 0);

        @(negedge clk);
        {rst, stall, jmp, jz, cal, ret, zf} = '0;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
